// File: rtl/c_readout.sv
// C memory readout: walks word addresses 0..N_WORDS-1 on the RA/CA/NCE port and streams
// the read data out through a 2-entry FIFO under valid/ready flow control.
module c_readout #(
  parameter int N_WORDS = 1024,
  parameter int DW      = 21
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          start,
  output logic [7:0]    RA,
  output logic [1:0]    CA,
  output logic          NCE,
  output logic          NWRT,
  input  logic [DW-1:0] DO,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic          dout_last,
  output logic          busy,
  output logic          finish
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  localparam logic [9:0] LAST_IDX = 10'(N_WORDS - 1);

  state_t          state, state_nxt;
  logic            start_q, start_edge;
  logic [9:0]      rd_idx;
  logic            last_rd, issue, pop, head_last;
  logic            inflight, inflight_last;
  logic [1:0]      cnt;
  logic [2:0]      occ;
  logic            rd_ptr, wr_ptr;
  logic [DW-1:0]   data_q [2];
  logic [1:0]      last_q;

  assign start_edge = start & ~start_q;
  assign last_rd    = (rd_idx == LAST_IDX);
  assign pop        = dout_valid & dout_ready;
  assign head_last  = last_q[rd_ptr];
  // Words buffered plus the one in flight, after this cycle's pop; pop implies cnt>=1.
  assign occ        = 3'(cnt) + 3'(inflight) - 3'(pop);

  assign dout_valid = (cnt != 2'd0);
  assign dout       = data_q[rd_ptr];
  assign dout_last  = dout_valid & head_last;
  assign RA         = rd_idx[9:2];
  assign CA         = rd_idx[1:0];
  assign NCE        = ~issue;
  assign NWRT       = 1'b1;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_edge)         state_nxt = READ;
      READ:    if (issue && last_rd)   state_nxt = DRAIN;
      DRAIN:   if (pop && head_last)   state_nxt = IDLE;
      default:                         state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state != IDLE);
    issue = (state == READ) && (occ < 3'd2);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      start_q       <= 1'b0;
      rd_idx        <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      finish        <= 1'b0;
    end else begin
      start_q       <= start;
      inflight      <= issue;
      inflight_last <= issue & last_rd;
      finish        <= pop & head_last;
      if (state == IDLE && start_edge) rd_idx <= '0;
      else if (issue && !last_rd)      rd_idx <= rd_idx + 10'd1;
    end
  end

  // Read data lands one cycle after its address cycle; occupancy rule keeps cnt<=2.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt    <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      last_q <= '0;
      for (int i = 0; i < 2; i++) data_q[i] <= '0;
    end else begin
      if (inflight) begin
        data_q[wr_ptr] <= DO;
        last_q[wr_ptr] <= inflight_last;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      cnt <= cnt + 2'(inflight) - 2'(pop);
    end
  end

endmodule
